// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter_if
//  Description : Bundle of the two writeback requester channels and the
//                register-file write port shared by rf_wb_arbiter.
//                master = requester/register-file side, slave = arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int DW = 16
);
    // Requester A (ALU writeback)
    logic           a_req;
    logic [3:0]     a_id;
    logic [DW-1:0]  a_data;
    logic           a_gnt;
    // Requester B (memory load)
    logic           b_req;
    logic [3:0]     b_id;
    logic [DW-1:0]  b_data;
    logic           b_gnt;
    // Register-file write port
    logic           wr_en;
    logic [3:0]     wr_id;
    logic [DW-1:0]  wr_data;
    // Contention statistics
    logic [15:0]    conflict_cnt;

    modport master (
        output a_req, a_id, a_data,
        output b_req, b_id, b_data,
        input  a_gnt, b_gnt,
        input  wr_en, wr_id, wr_data,
        input  conflict_cnt
    );

    modport slave (
        input  a_req, a_id, a_data,
        input  b_req, b_id, b_data,
        output a_gnt, b_gnt,
        output wr_en, wr_id, wr_data,
        output conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Two-requester round-robin arbiter for the single register
//                file write port. Grants are combinational in the request
//                cycle; the winning id/data appear on the write port one
//                cycle later. Counts contested cycles (saturating).
//                Optional macro RF_R0_ZERO_EN: writes to register 0 are
//                granted but suppressed (R0 reads as constant zero).
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DW = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    rf_wb_arbiter_if.slave      bus
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;
    localparam logic [3:0]  c_R0_ID   = 4'd0;

    // Round-robin pointer: which requester wins when both ask.
    typedef enum logic [0:0] {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t          r_prio;
    logic           r_wr_en;
    logic [3:0]     r_wr_id;
    logic [DW-1:0]  r_wr_data;
    logic [15:0]    r_conflict_cnt;

    logic           w_a_gnt;
    logic           w_b_gnt;
    logic           w_any_gnt;
    logic           w_both_req;
    logic [3:0]     w_win_id;
    logic [DW-1:0]  w_win_data;
    logic           w_wr_en_nxt;

    // Grant decision; gated by rst_n so no grant is visible during reset.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (rst_n) begin
            if (bus.a_req && (!bus.b_req || (r_prio == PRIO_A))) begin
                w_a_gnt = 1'b1;
            end else if (bus.b_req) begin
                w_b_gnt = 1'b1;
            end
        end
    end

    // Winner selection and next write-enable (R0 suppression optional).
    always_comb begin
        w_any_gnt  = w_a_gnt | w_b_gnt;
        w_both_req = bus.a_req & bus.b_req;
        w_win_id   = w_a_gnt ? bus.a_id   : bus.b_id;
        w_win_data = w_a_gnt ? bus.a_data : bus.b_data;
`ifdef RF_R0_ZERO_EN
        w_wr_en_nxt = w_any_gnt && (w_win_id != c_R0_ID);
`else
        w_wr_en_nxt = w_any_gnt;
`endif
    end

    // Pointer moves to the loser after any grant, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= PRIO_A;
        end else if (w_a_gnt) begin
            r_prio <= PRIO_B;
        end else if (w_b_gnt) begin
            r_prio <= PRIO_A;
        end
    end

    // Registered write port: one write per grant, id/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_id   <= 4'd0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_en_nxt;
            if (w_any_gnt) begin
                r_wr_id   <= w_win_id;
                r_wr_data <= w_win_data;
            end
        end
    end

    // Saturating count of cycles in which both requesters asked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= 16'd0;
        end else if (w_both_req && (r_conflict_cnt != c_CNT_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign bus.a_gnt        = w_a_gnt;
    assign bus.b_gnt        = w_b_gnt;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_id        = r_wr_id;
    assign bus.wr_data      = r_wr_data;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16, register data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port a_req  input  1  requester A (ALU writeback) write request.
REQ-005 SHALL have port a_id  input  4  requester A destination register.
REQ-006 SHALL have port a_data  input  DW  requester A write data.
REQ-007 SHALL have port a_gnt  output  1  requester A granted this cycle.
REQ-008 SHALL have port b_req  input  1  requester B (memory load) write request.
REQ-009 SHALL have port b_id  input  4  requester B destination register.
REQ-010 SHALL have port b_data  input  DW  requester B write data.
REQ-011 SHALL have port b_gnt  output  1  requester B granted this cycle.
REQ-012 SHALL have port wr_en  output  1  register-file write enable; drives the write decoder WriteReg.
REQ-013 SHALL have port wr_id  output  4  register-file write address; drives the write decoder RegId.
REQ-014 SHALL have port wr_data  output  DW  register-file write data.
REQ-015 SHALL have port conflict_cnt  output  16  count of cycles with both requests active.

Function
REQ-016 SHALL share the single register-file write port between A and B, granting at most one requester per cycle.
REQ-017 SHALL compute a_gnt/b_gnt combinationally in the same cycle as the request; a_gnt and b_gnt SHALL never both be 1.
REQ-018 SHALL keep one-bit round-robin pointer prio (0=A favoured, 1=B favoured) as the arbitration state.
REQ-019 Single requester: SHALL grant it regardless of prio; both requesting: SHALL grant the one prio favours; neither: no grant.
REQ-020 After any grant, prio SHALL point to the non-granted requester (grant A -> prio=1, grant B -> prio=0); with no grant, prio SHALL hold.
REQ-021 Winner's id and data SHALL be registered at the granting edge; wr_en=1 with those wr_id/wr_data in the following cycle (latency 1 cycle grant -> write).
REQ-022 Cycle with no grant SHALL be followed by wr_en=0; wr_id/wr_data SHALL hold their last values.
REQ-023 Requester SHALL hold req/id/data stable until it samples gnt=1; a request dropped before grant is abandoned with no write.
REQ-024 Back-to-back grants SHALL produce wr_en=1 in consecutive cycles (full throughput, one write per cycle).
REQ-025 A and B targeting the same register SHALL both be written in grant order; the later grant's data is the final value.
REQ-026 conflict_cnt SHALL increment by 1 on every rising edge where a_req=b_req=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force wr_en=0, wr_id=0, wr_data=0, conflict_cnt=0, prio=0.
REQ-028 a_gnt and b_gnt SHALL be 0 while rst_n=0.
REQ-029 Reset asserted mid-stream SHALL discard the pending registered write; first contested grant after release SHALL go to A.

Configuration
REQ-030 Macro RF_R0_ZERO_EN defined: a granted write with id 0 SHALL pulse gnt and advance prio normally but SHALL leave wr_en=0 next cycle (R0 read-only zero).
REQ-031 RF_R0_ZERO_EN undefined: id 0 SHALL be written like any other register.

Verification
REQ-032 Reset: rst_n=0 with a_req=b_req=1 -> a_gnt=b_gnt=0, wr_en=0, wr_id=0, wr_data=0, conflict_cnt=0, no clock needed.
REQ-033 A only, a_id=3, a_data=16'hBEEF -> a_gnt=1 same cycle; next cycle wr_en=1, wr_id=3, wr_data=16'hBEEF; following cycle wr_en=0.
REQ-034 Both request 4 cycles (A: id 1/16'h1111, B: id 2/16'h2222) -> grants A,B,A,B; writes alternate id 1,2,1,2 on consecutive cycles; conflict_cnt=4.
REQ-035 Both target id 5 (A 16'hAAAA, B 16'hBBBB) from reset -> write 5/AAAA then 5/BBBB; final register value 16'hBBBB.
REQ-036 a_id=0, a_data=16'h1234: with RF_R0_ZERO_EN -> a_gnt=1, wr_en stays 0; without -> wr_en=1, wr_id=0, wr_data=16'h1234.
REQ-037 rst_n pulsed low after a B grant, before its write cycle -> wr_en=0 immediately, no write; after release both requesting -> A granted first.
